// File: rtl/tree_pkg.sv
// Shared definitions for the decision-tree walker: node word layout, error
// codes and walker state encoding.
package tree_pkg;

  localparam int NODE_BITS  = 108;
  localparam int NODE_ID_HI = 107;
  localparam int NODE_ID_LO = 96;
  localparam int KIND_HI    = 95;
  localparam int KIND_LO    = 92;
  localparam int THR_HI     = 91;
  localparam int THR_LO     = 28;
  localparam int LEFT_HI    = 27;
  localparam int LEFT_LO    = 16;
  localparam int RIGHT_HI   = 15;
  localparam int RIGHT_LO   = 4;
  localparam int CLASS_HI   = 3;
  localparam int CLASS_LO   = 0;

  localparam logic [3:0] LEAF_KIND = 4'h3;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_DEPTH = 2'd1;
  localparam logic [1:0] ERR_ID    = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } walk_state_e;

  typedef struct packed {
    logic [11:0] node_id;
    logic [3:0]  kind;
    logic [63:0] thr;
    logic [11:0] left;
    logic [11:0] right;
    logic [3:0]  cls;
  } node_t;

  function automatic node_t decode_node(input logic [NODE_BITS-1:0] w);
    node_t n;
    n.node_id = w[NODE_ID_HI:NODE_ID_LO];
    n.kind    = w[KIND_HI:KIND_LO];
    n.thr     = w[THR_HI:THR_LO];
    n.left    = w[LEFT_HI:LEFT_LO];
    n.right   = w[RIGHT_HI:RIGHT_LO];
    n.cls     = w[CLASS_HI:CLASS_LO];
    return n;
  endfunction

endpackage

// File: rtl/fp64_le_cmp.sv
// Combinational binary64 a <= b. NaN on either side yields false; signed
// zeros compare equal.
module fp64_le_cmp (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        le_o
);

  logic a_nan, b_nan, both_zero, mag_le, mag_ge;

  assign a_nan     = (&a_i[62:52]) && (|a_i[51:0]);
  assign b_nan     = (&b_i[62:52]) && (|b_i[51:0]);
  assign both_zero = ~(|a_i[62:0]) && ~(|b_i[62:0]);
  assign mag_le    = a_i[62:0] <= b_i[62:0];
  assign mag_ge    = a_i[62:0] >= b_i[62:0];

  // Sign-magnitude: negative operands order by reversed magnitude.
  always_comb begin
    le_o = 1'b0;
    if (a_nan || b_nan)         le_o = 1'b0;
    else if (both_zero)         le_o = 1'b1;
    else if (a_i[63] != b_i[63]) le_o = a_i[63];
    else if (a_i[63])           le_o = mag_ge;
    else                        le_o = mag_le;
  end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walker: fetches nodes from an external synchronous ROM,
// compares the selected feature to each threshold and reports the leaf class.
module tree_walk_ctrl
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int ROM_DEPTH  = 512,
  parameter int MAX_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [NODE_WIDTH-1:0] rom_data,
  output logic [3:0]            feat_idx,
  input  logic [63:0]           feat_val,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [3:0]            result_class,
  output logic [1:0]            result_err,
  output logic [5:0]            result_depth
);

  walk_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [5:0]            depth_q, depth_d;
  logic [3:0]            cls_q, cls_d;
  logic [1:0]            err_q, err_d;

  node_t       node;
  logic        go_left;
  logic [11:0] child;
  logic        id_match, is_leaf, depth_ovf, child_oob;

  assign node = decode_node(rom_data[NODE_BITS-1:0]);

  if (NODE_WIDTH > NODE_BITS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rom_data[NODE_WIDTH-1:NODE_BITS];
  end

  fp64_le_cmp u_cmp (
    .a_i  (feat_val),
    .b_i  (node.thr),
    .le_o (go_left)
  );

  assign child     = go_left ? node.left : node.right;
  assign id_match  = int'(node.node_id) == int'(addr_q);
  assign is_leaf   = node.kind == LEAF_KIND;
  assign depth_ovf = (int'(depth_q) + 1) > MAX_DEPTH;
  assign child_oob = int'(child) >= ROM_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      depth_q <= '0;
      cls_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    depth_d = depth_q;
    cls_d   = cls_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          addr_d  = '0;
          depth_d = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = ST_DONE;
        cls_d   = '0;
        // Id check outranks everything: a corrupt word's other fields are untrusted.
        if (!id_match) begin
          err_d = ERR_ID;
        end else if (is_leaf) begin
          cls_d = node.cls;
          err_d = ERR_OK;
        end else if (depth_ovf) begin
          err_d = ERR_DEPTH;
        end else begin
          depth_d = depth_q + 6'd1;
          if (child_oob) begin
            err_d = ERR_RANGE;
          end else begin
            addr_d  = ADDR_WIDTH'(child);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: if (result_ready) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready  = state_q == ST_IDLE;
    result_valid = state_q == ST_DONE;
    feat_idx     = (state_q == ST_EVAL) ? node.kind : 4'd0;
    rom_addr     = addr_q;
    result_class = cls_q;
    result_err   = err_q;
    result_depth = depth_q;
  end

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Bench for tree_walk_ctrl: ROM image model, path-level reference walk using
// real arithmetic, per-cycle compare plus literal expectations per scenario.
module tb_tree_walk_ctrl;

  localparam int MAXD = 32;

  localparam logic [63:0] F_P0   = 64'h0000000000000000;
  localparam logic [63:0] F_N0   = 64'h8000000000000000;
  localparam logic [63:0] F_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] F_MONE = 64'hBFF0000000000000;
  localparam logic [63:0] F_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] F_NAN  = 64'h7FF8000000000000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [9:0]   rom_addr;
  logic [119:0] rom_data = '0;
  logic [3:0]   feat_idx;
  logic [63:0]  feat_val;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [3:0]   result_class;
  logic [1:0]   result_err;
  logic [5:0]   result_depth;

  logic [119:0] rom [1024];
  logic [63:0]  feats [16];

  int errors = 0;
  int checks = 0;

  // Reference results for the current request
  int m_path [64];
  int m_kind [64];
  int m_lat, m_err, m_cls, m_depth;

  bit active = 1'b0;
  int cyc = 0;

  tree_walk_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .feat_idx     (feat_idx),
    .feat_val     (feat_val),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_err   (result_err),
    .result_depth (result_depth)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];
  assign feat_val = feats[feat_idx];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [119:0] mk(input int id, input logic [3:0] kind,
                                      input logic [63:0] thr, input int l,
                                      input int r, input logic [3:0] cls);
    logic [119:0] w;
    w = '0;
    w[107:96] = 12'(id);
    w[95:92]  = kind;
    w[91:28]  = thr;
    w[27:16]  = 12'(l);
    w[15:4]   = 12'(r);
    w[3:0]    = cls;
    return w;
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    for (int i = 0; i < 16; i++) feats[i] = F_P0;
  endtask

  // Reference walk: follows the rules on the whole ROM image using real-valued compares.
  task automatic model_walk();
    int a, d, n;
    bit fin;
    logic [119:0] nd;
    int child;
    real fv, th;
    a = 0; d = 0; n = 0; fin = 0;
    m_cls = 0; m_err = 0;
    while (!fin) begin
      nd = rom[a];
      m_path[n] = a;
      m_kind[n] = int'(nd[95:92]);
      n++;
      if (int'(nd[107:96]) != a) begin
        m_err = 2; fin = 1;
      end else if (nd[95:92] == 4'h3) begin
        m_cls = int'(nd[3:0]); m_err = 0; fin = 1;
      end else begin
        fv = $bitstoreal(feats[nd[95:92]]);
        th = $bitstoreal(nd[91:28]);
        child = (fv <= th) ? int'(nd[27:16]) : int'(nd[15:4]);
        if (d + 1 > MAXD) begin
          m_err = 1; fin = 1;
        end else begin
          d++;
          if (child >= 512) begin
            m_err = 3; fin = 1;
          end else a = child;
        end
      end
    end
    m_lat = 2 * n;
    m_depth = d;
  endtask

  // Reference timeline: cycle count since the accept edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cyc <= 0;
    end else if (!active) begin
      if (start_valid) begin
        active <= 1'b1;
        cyc <= 0;
      end
    end else if (cyc >= m_lat && result_ready) begin
      active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", start_ready, 1);
      chk("rst_valid", result_valid, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_feat", feat_idx, 0);
      chk("rst_class", result_class, 0);
      chk("rst_err", result_err, 0);
      chk("rst_depth", result_depth, 0);
    end else if (!active) begin
      chk("idle_ready", start_ready, 1);
      chk("idle_valid", result_valid, 0);
      chk("idle_feat", feat_idx, 0);
    end else if (cyc < m_lat) begin
      chk("busy_ready", start_ready, 0);
      chk("busy_valid", result_valid, 0);
      chk("walk_addr", rom_addr, m_path[cyc/2]);
      chk("walk_feat", feat_idx, (cyc % 2 == 1) ? m_kind[cyc/2] : 0);
    end else begin
      chk("done_ready", start_ready, 0);
      chk("done_valid", result_valid, 1);
      chk("done_err", result_err, m_err);
      chk("done_depth", result_depth, m_depth);
      if (m_err == 0) chk("done_class", result_class, m_cls);
    end
  end

  // Issue one request and check the outcome against hand-computed values.
  task automatic run(input string nm, input int e_cls, input int e_err,
                     input int e_dep, input int e_lat, input int hold,
                     input bit hold_sv);
    int cnt;
    logic [3:0] c0;
    logic [1:0] e0;
    logic [5:0] d0;
    model_walk();
    @(posedge clk); #1;
    start_valid = 1'b1;
    result_ready = 1'b0;
    @(posedge clk); #1;
    if (!hold_sv) start_valid = 1'b0;
    cnt = 0;
    while (!result_valid && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    start_valid = 1'b0;
    if (!result_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_lat"}, cnt, e_lat);
    chk({nm, "_err"}, result_err, e_err);
    chk({nm, "_depth"}, result_depth, e_dep);
    if (e_err == 0) chk({nm, "_class"}, result_class, e_cls);
    c0 = result_class; e0 = result_err; d0 = result_depth;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, result_valid, 1);
      chk({nm, "_hold_class"}, result_class, c0);
      chk({nm, "_hold_err"}, result_err, e0);
      chk({nm, "_hold_depth"}, result_depth, d0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({nm, "_back_idle"}, start_ready, 1);
  endtask

  // Chain 0..6: even nodes go left (0 <= 1.0), odd nodes go right (0 > -1.0).
  task automatic img_tree8();
    int kk;
    clear_image();
    for (int k = 0; k < 6; k++) begin
      kk = (k < 3) ? k : k + 1;
      if (k % 2 == 0) rom[k] = mk(k, 4'(kk), F_ONE, k + 1, 'h1FF, 4'h0);
      else            rom[k] = mk(k, 4'(kk), F_MONE, 'h1FF, k + 1, 4'h0);
    end
    rom[6] = mk(6, 4'h3, F_P0, 0, 0, 4'h1);
  endtask

  initial begin
    clear_image();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    img_tree8();
    run("tree8", 1, 0, 6, 14, 0, 1'b0);

    clear_image();
    rom[0] = mk(0, 4'h3, F_P0, 0, 0, 4'h5);
    run("rootleaf", 5, 0, 0, 2, 0, 1'b0);

    clear_image();
    rom[0] = mk(0, 4'h2, F_ONE, 1, 'h11E, 4'h0);
    feats[2] = F_INF;
    run("idmis", 0, 2, 1, 4, 0, 1'b0);

    clear_image();
    rom[0] = mk(0, 4'h1, F_ONE, 1, 2, 4'h0);
    rom[1] = mk(1, 4'h3, F_P0, 0, 0, 4'h7);
    rom[2] = mk(2, 4'h3, F_P0, 0, 0, 4'h9);
    feats[1] = F_NAN;
    run("nan", 9, 0, 1, 4, 0, 1'b1);

    rom[0] = mk(0, 4'h1, F_P0, 1, 2, 4'h0);
    feats[1] = F_N0;
    run("negzero", 7, 0, 1, 4, 0, 1'b0);

    clear_image();
    rom[0] = mk(0, 4'h0, F_P0, 0, 0, 4'h0);
    run("loop", 0, 1, MAXD, 2 * (MAXD + 1), 5, 1'b0);

    clear_image();
    rom[0] = mk(0, 4'h0, F_ONE, 'h200, 1, 4'h0);
    run("range", 0, 3, 1, 2, 0, 1'b0);

    // Reset during the EVAL of node 3 (depth 3), then a clean request.
    img_tree8();
    model_walk();
    @(posedge clk); #1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_addr", rom_addr, 3);
    chk("mid_feat", feat_idx, 4);
    chk("mid_depth", result_depth, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", start_ready, 1);
    chk("arst_valid", result_valid, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_feat", feat_idx, 0);
    chk("arst_depth", result_depth, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid", result_valid, 0);
    run("after_rst", 1, 0, 6, 14, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
